// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_detector_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'b00,
    FILL  = 2'b01,
    RUN   = 2'b10
  } seqdet_state_t;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seqdet_match_counter.sv
// rtl/seqdet_match_counter.sv - saturating match counter with synchronous clear
module seqdet_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial pattern detector
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detector_prog
  import seq_detector_pkg::*;
#(
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 16,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               cfg_err,
  output logic [1:0]         state
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_count,
  input  logic               count_clr
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  if ((MAX_LEN < 2) || (CNT_W < 1)) begin : g_param_check
    $error("seq_detector_prog: MAX_LEN must be >= 2 and CNT_W >= 1");
  end

  seqdet_state_t      state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               cfg_len_ok;
  logic               hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hist_n     = {hist_q[MAX_LEN-2:0], in_bit};
  assign fill_n     = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    hit       = 1'b0;

    // A config load takes the cycle; any coincident data bit is dropped.
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (cfg_len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        state_d   = FILL;
      end else begin
        pattern_d = '0;
        len_d     = '0;
        overlap_d = 1'b0;
        cfg_err_d = 1'b1;
        state_d   = UNCFG;
      end
    end else if (in_valid && (state_q != UNCFG)) begin
      hit     = (fill_n == len_q) && ((hist_n & mask) == (pattern_q & mask));
      match_d = hit;
      // Non-overlap restarts collection so the next match needs len fresh bits.
      if (hit && !overlap_q) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end else begin
        hist_d  = hist_n;
        fill_d  = fill_n;
        state_d = (fill_n == len_q) ? RUN : FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNCFG;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match   = match_q;
  assign cfg_err = cfg_err_q;
  assign state   = state_q;

`ifdef SEQDET_MATCH_CNT_EN
  seqdet_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (count_clr),
    .inc   (hit),
    .count (match_count)
  );
`endif

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector; generalised successor to the fixed 5-state detector FSM.
- Pattern value, length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config strobe.
- Sits on a serial bit stream with a valid qualifier and emits a registered one-cycle match pulse, plus an optional saturating match counter.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 16: match counter width. Used only with the optional feature.
- Derived localparam LEN_W = $clog2(MAX_LEN+1). Not overridable.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe; captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern bits. Bit [cfg_len-1] is the first bit received, bit [0] the last. Bits above cfg_len-1 are ignored.
- cfg_len  input  LEN_W  pattern length. Legal range is 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  in_bit is accepted this cycle.
- in_bit  input  1  serial data bit.
- match  output  1  registered pulse; high for the one cycle after the accepted bit that completes the pattern.
- cfg_err  output  1  registered pulse; high for one cycle after a cfg_load with an illegal length.
- state  output  2  current state: 00 UNCFG, 01 FILL, 10 RUN.
- match_count  output  CNT_W  saturating match count. Exists only with the optional feature.
- count_clr  input  1  clears match_count. Exists only with the optional feature.

Behaviour:
- Reset: state=UNCFG; hist, fill, pattern and length registers = 0; overlap register = 0; match=0; cfg_err=0; match_count=0.
- Registers:
  - hist: MAX_LEN-bit shift register, shifted left, new bit in at [0].
  - fill: count of bits accepted since the last clear, saturating at len.
  - mask: low len bits set.
- UNCFG: in_valid is ignored; match stays 0.
- cfg_load, legal cfg_len: capture all config; hist=0; fill=0; next state=FILL. Valid in any state.
- cfg_load, illegal cfg_len (0 or >MAX_LEN): next state=UNCFG; cfg_err pulses; stored config is invalidated.
- cfg_load has priority over in_valid in the same cycle. The coincident bit is dropped.
- Accepted bit (in_valid=1, no cfg_load, state != UNCFG):
  - hist_n = {hist[MAX_LEN-2:0], in_bit}.
  - fill_n = min(fill+1, len).
  - hit = (fill_n == len) && ((hist_n & mask) == (pattern & mask)).
  - match <= hit, so latency is one cycle after the completing bit.
- Match in overlap mode: hist <= hist_n, fill <= fill_n; state stays RUN.
- Match in non-overlap mode: hist <= 0, fill <= 0; next state=FILL. A new match needs len fresh bits.
- State tracking: state=FILL while fill<len, RUN when fill==len, subject to the non-overlap rule above.
- len=1: every accepted bit equal to pattern[0] matches, in both modes.
- in_valid=0: no register change; match=0 next cycle.
- match is 0 on any cycle not preceded by a hit.
- Reset mid-stream: returns to UNCFG; configuration must be reloaded.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined:
  - match_count and count_clr ports exist.
  - match_count increments on each cycle where hit=1 and saturates at all-ones.
  - count_clr has priority over a coincident hit; result is 0.
  - cfg_load does not clear the counter.
- Undefined: both ports are absent; no counter logic is generated.

Decomposition:
- Package seq_detector_pkg holds:
  - state enum typedef seqdet_state_t (UNCFG=2'b00, FILL=2'b01, RUN=2'b10);
  - the LEN_W helper function.
- One natural sub-module: seqdet_match_counter (saturating counter with clear), instantiated only under SEQDET_MATCH_CNT_EN.

Test Plan:
- Config 5'b10110, len=5, overlap=1; stream 1,0,1,1,0,1,1,0, one bit per cycle → match high the cycle after bit 5 and after bit 8; count=2.
- Same stream with overlap=0 → match only after bit 5; state returns to 01 after the match; count=1.
- cfg_len=0, then cfg_len=9 (MAX_LEN=8) → cfg_err pulses each time; state=00; stream 1,1,1 → no match.
- len=1, pattern=1, overlap=0; stream 1,1,0,1 → match after bits 1, 2 and 4.
- Pattern 10110 with gaps: in_valid low for 3 cycles between bits 3 and 4 → match still after bit 5; match=0 during gaps. Reset asserted after bit 3 → state=00 and subsequent bits are ignored.
- With SEQDET_MATCH_CNT_EN, CNT_W=2: 4 matches → count saturates at 3; count_clr coincident with a hit → count=0.
